// File: rtl/if_stage_if.sv
// Fetch-stage bundle: hazard/branch controls, instruction-memory port and the IF/ID outputs.
// master = fetch stage, slave = its environment (hazard unit, memory, decoder).
interface if_stage_if #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned ADDR_WIDTH = 10
);
   localparam int unsigned PC_W = ADDR_WIDTH + 2;

   logic                  stall;
   logic                  redirect;
   logic [PC_W-1:0]       redirect_pc;
   logic                  imem_en;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [WIDTH-1:0]      imem_rdata;
   logic [WIDTH-1:0]      instruction;
   logic [PC_W-1:0]       pc;
   logic                  valid;
   logic                  predicted_taken;

   modport master (
      input  stall, redirect, redirect_pc, imem_rdata,
      output imem_en, imem_addr, instruction, pc, valid, predicted_taken
   );

   modport slave (
      output stall, redirect, redirect_pc, imem_rdata,
      input  imem_en, imem_addr, instruction, pc, valid, predicted_taken
   );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, sync imem read port, IF/ID register and a one-entry skid buffer.
// Optional JMP predecode with self-redirect is enabled by defining IF_JMP_PREDECODE_EN.
module if_stage #(
   parameter int unsigned           WIDTH      = 32,
   parameter int unsigned           ADDR_WIDTH = 10,
   parameter logic [ADDR_WIDTH+1:0] RESET_PC   = '0
) (
   input  logic      clk,
   input  logic      reset,
   if_stage_if.master bus
);
   localparam int unsigned PC_W   = ADDR_WIDTH + 2;
   localparam logic [2:0]  OP_JMP = 3'b110;

   typedef enum logic [1:0] {BOOT, RUN, HOLD} state_e;

   typedef struct packed {
      logic [WIDTH-1:0] instr;
      logic [PC_W-1:0]  pc;
   } entry_t;

   state_e          state_q, state_d;
   logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
   logic            inflight_q, inflight_d;
   logic [PC_W-1:0] tag_q, tag_d;
   entry_t          skid_q, skid_d;
   logic            skid_full_q, skid_full_d;
   entry_t          ifid_q, ifid_d;
   logic            valid_q, valid_d;

   logic            self_redir_c;
   logic [PC_W-1:0] self_tgt_c;
   logic            redir_c;
   logic [PC_W-1:0] issue_pc_c;
   logic            issue_c;
   logic            resp_live_c;
   entry_t          resp_c;

   // External redirect beats the self-redirect; low two target bits are dropped
   always_comb begin
      redir_c    = bus.redirect | self_redir_c;
      issue_pc_c = fetch_pc_q;
      if (bus.redirect)
         issue_pc_c = {bus.redirect_pc[PC_W-1:2], 2'b00};
      else if (self_redir_c)
         issue_pc_c = self_tgt_c;
      issue_c = reset & (redir_c | ~bus.stall);
   end

   assign bus.imem_en   = issue_c;
   assign bus.imem_addr = issue_pc_c[PC_W-1:2];

   // A response seen in BOOT belongs to a fetch issued before reset
   assign resp_live_c = inflight_q & (state_q != BOOT);
   assign resp_c      = '{instr: bus.imem_rdata, pc: tag_q};

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      inflight_d  = 1'b0;
      tag_d       = tag_q;
      skid_d      = skid_q;
      skid_full_d = skid_full_q;
      ifid_d      = ifid_q;
      valid_d     = valid_q;

      if (issue_c) begin
         fetch_pc_d = issue_pc_c + PC_W'(4);
         inflight_d = 1'b1;
         tag_d      = issue_pc_c;
      end

      if (redir_c) begin
         // Flush: drop skid and the old in-flight word; a stalled JMP keeps its slot
         state_d     = RUN;
         skid_full_d = 1'b0;
         if (bus.redirect || !bus.stall)
            valid_d = 1'b0;
      end else if (bus.stall) begin
         state_d = HOLD;
         if (resp_live_c) begin
            skid_d      = resp_c;
            skid_full_d = 1'b1;
         end
      end else begin
         state_d = RUN;
         if (skid_full_q) begin
            ifid_d      = skid_q;
            valid_d     = 1'b1;
            skid_d      = resp_c;
            skid_full_d = resp_live_c;
         end else if (resp_live_c) begin
            ifid_d  = resp_c;
            valid_d = 1'b1;
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= BOOT;
         fetch_pc_q  <= RESET_PC;
         inflight_q  <= 1'b0;
         tag_q       <= '0;
         skid_q      <= '0;
         skid_full_q <= 1'b0;
         ifid_q      <= '0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         inflight_q  <= inflight_d;
         tag_q       <= tag_d;
         skid_q      <= skid_d;
         skid_full_q <= skid_full_d;
         ifid_q      <= ifid_d;
         valid_q     <= valid_d;
      end
   end

   assign bus.instruction = ifid_q.instr;
   assign bus.pc          = ifid_q.pc;
   assign bus.valid       = valid_q;

`ifdef IF_JMP_PREDECODE_EN
   logic            jmp_pend_q, jmp_pend_d;
   logic [PC_W-1:0] jmp_tgt_q, jmp_tgt_d;
   logic            pt_q, pt_d;
   logic            load_c;

   assign self_redir_c = jmp_pend_q;
   assign self_tgt_c   = jmp_tgt_q;
   assign load_c       = ~redir_c & ~bus.stall & (skid_full_q | resp_live_c);

   // Predecode whatever word lands in IF/ID this edge
   always_comb begin
      jmp_pend_d = 1'b0;
      jmp_tgt_d  = jmp_tgt_q;
      pt_d       = pt_q;
      if (load_c) begin
         pt_d       = (ifid_d.instr[WIDTH-1 -: 3] == OP_JMP);
         jmp_pend_d = pt_d;
         jmp_tgt_d  = {ifid_d.instr[PC_W-1:2], 2'b00};
      end else if (!valid_d) begin
         pt_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         jmp_pend_q <= 1'b0;
         jmp_tgt_q  <= '0;
         pt_q       <= 1'b0;
      end else begin
         jmp_pend_q <= jmp_pend_d;
         jmp_tgt_q  <= jmp_tgt_d;
         pt_q       <= pt_d;
      end
   end

   assign bus.predicted_taken = pt_q;
`else
   assign self_redir_c        = 1'b0;
   assign self_tgt_c          = '0;
   assign bus.predicted_taken = 1'b0;
`endif
endmodule
